// File: rtl/popcount_frame_accumulator.sv
// rtl/popcount_frame_accumulator.sv - frame popcount accumulator over a bank of 5:3 counter triples
// Optional build macro: POPACC_SAT_EN (saturate instead of wrapping on overflow).
module popcount_frame_accumulator #(
    parameter int LANES = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [LANES-1:0] in_sum,
    input  logic [LANES-1:0] in_carry,
    input  logic [LANES-1:0] in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_err
);

    localparam int S1W = $clog2(7*LANES+1);

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;

    logic [S1W-1:0]   lane_sum;
    logic             lane_err;

    logic             s1_valid;
    logic             s1_last;
    logic             s1_err;
    logic [S1W-1:0]   s1_val;

    logic [ACC_W-1:0] acc;
    logic             first;
    logic             ovf_f;
    logic             err_f;

    logic [ACC_W:0]   s1_ext;
    logic [ACC_W:0]   acc_base;
    logic [ACC_W:0]   nacc;
    logic             ovf_now;
    logic             err_now;
    logic [ACC_W-1:0] acc_nxt;

    assign accept = in_valid & in_ready;

    // Codes 6 and 7 are the only ones with both the weight-4 and weight-2 bits set.
    always_comb begin
        lane_sum = '0;
        lane_err = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + S1W'({in_cout[i], in_carry[i], in_sum[i]});
            lane_err = lane_err | (in_cout[i] & in_carry[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_err   <= 1'b0;
            s1_val   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_last  <= in_last;
            s1_err   <= lane_err;
            s1_val   <= lane_sum;
        end else begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: the first beat of a frame starts from zero and clears the sticky flags.
    always_comb begin
        s1_ext   = (ACC_W+1)'(s1_val);
        acc_base = first ? '0 : {1'b0, acc};
        nacc     = acc_base + s1_ext;
        ovf_now  = nacc[ACC_W] | (~first & ovf_f);
        err_now  = s1_err | (~first & err_f);
`ifdef POPACC_SAT_EN
        acc_nxt  = ovf_now ? {ACC_W{1'b1}} : nacc[ACC_W-1:0];
`else
        acc_nxt  = nacc[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            first     <= 1'b1;
            ovf_f     <= 1'b0;
            err_f     <= 1'b0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
        end else if (s1_valid) begin
            if (s1_last) begin
                out_count <= acc_nxt;
                out_ovf   <= ovf_now;
                out_err   <= err_now;
                acc       <= '0;
                first     <= 1'b1;
                ovf_f     <= 1'b0;
                err_f     <= 1'b0;
            end else begin
                acc   <= acc_nxt;
                first <= 1'b0;
                ovf_f <= ovf_now;
                err_f <= err_now;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && in_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (s1_valid && s1_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// tb/tb_popcount_frame_accumulator.sv - directed self-checking bench for popcount_frame_accumulator
module tb_popcount_frame_accumulator;

    localparam int LANES = 4;
    localparam int ACC_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [LANES-1:0] in_sum;
    logic [LANES-1:0] in_carry;
    logic [LANES-1:0] in_cout;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_count;
    logic             out_ovf;
    logic             out_err;

    int n_cmp = 0;
    int n_bad = 0;

    popcount_frame_accumulator #(.LANES(LANES), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_cout   (in_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat of lane codes c0..c3 for one cycle (block assumed to be in ACCUM).
    task automatic beat(input int c0, input int c1, input int c2, input int c3, input bit last);
        int c[4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        for (int i = 0; i < LANES; i++) begin
            in_sum[i]   = c[i][0];
            in_carry[i] = c[i][1];
            in_cout[i]  = c[i][2];
        end
        check("beat_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the last beat's accepting edge; checks DRAIN, HOLD, and handoff.
    task automatic finish_frame(input string tag, input int exp_count, input bit exp_ovf,
                                input bit exp_err, input int hold_cycles);
        check({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_count"}, {24'd0, out_count}, exp_count);
        check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, exp_ovf});
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        check({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < hold_cycles; k++) begin
            tick();
            check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_stall_count"}, {24'd0, out_count}, exp_count);
            check({tag, "_stall_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_done_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_kept_count"}, {24'd0, out_count}, exp_count);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        in_cout   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_count", {24'd0, out_count}, 32'd0);
        check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Three beats of all-code-5: 3 * 20 = 60.
        beat(5, 5, 5, 5, 1'b0);
        beat(5, 5, 5, 5, 1'b0);
        beat(5, 5, 5, 5, 1'b1);
        finish_frame("f3x5", 60, 1'b0, 1'b0, 0);

        // Single beat 3+0+1+2 = 6 with a 5-cycle consumer stall; out_ready while idle is ignored.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_ready_ignored", {31'd0, out_valid}, 32'd0);
        beat(3, 0, 1, 2, 1'b1);
        finish_frame("single", 6, 1'b0, 1'b0, 5);

        // 13 * 20 = 260: wraps to 4, or clamps to 255 when saturating.
        for (int b = 0; b < 12; b++) beat(5, 5, 5, 5, 1'b0);
        beat(5, 5, 5, 5, 1'b1);
`ifdef POPACC_SAT_EN
        finish_frame("ovf", 255, 1'b1, 1'b0, 0);
`else
        finish_frame("ovf", 4, 1'b1, 1'b0, 0);
`endif
        beat(1, 1, 1, 1, 1'b1);
        finish_frame("post_ovf", 4, 1'b0, 1'b0, 0);

        // Illegal code 7 in lane 0 still adds its raw value and flags the frame.
        beat(7, 0, 0, 0, 1'b1);
        finish_frame("illegal", 7, 1'b0, 1'b1, 0);
        beat(1, 0, 0, 0, 1'b1);
        finish_frame("post_illegal", 1, 1'b0, 1'b0, 0);

        // Partial frame of 40 discarded by an asynchronous reset pulse.
        beat(5, 5, 5, 5, 1'b0);
        beat(5, 5, 5, 5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_count", {24'd0, out_count}, 32'd0);
        check("midrst_out_ovf", {31'd0, out_ovf}, 32'd0);
        check("midrst_out_err", {31'd0, out_err}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        beat(5, 5, 0, 0, 1'b1);
        finish_frame("after_rst", 10, 1'b0, 1'b0, 0);

        // Four beats of {1,1,1,1} with idle gaps between them: 16.
        beat(1, 1, 1, 1, 1'b0);
        tick();
        tick();
        beat(1, 1, 1, 1, 1'b0);
        tick();
        beat(1, 1, 1, 1, 1'b0);
        tick();
        tick();
        tick();
        beat(1, 1, 1, 1, 1'b1);
        finish_frame("gaps", 16, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
